// File: rtl/l2_arbiter.sv
// rtl/l2_arbiter.sv - round-robin arbiter sharing one L2 request port between I-cache and D-cache
// One transaction at a time; request fields are latched at grant and held until L2 completes.
module l2_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  i_stall_count,
  output logic [CNT_W-1:0]  d_stall_count,
  output logic [CNT_W-1:0]  conflict_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } state_t;

  state_t state;
  state_t state_next;
  logic   last_d;
  logic   op_write;
  logic   d_req;
  logic   grant_i;
  logic   grant_d;
  logic   conflict;

  assign d_req    = d_read | d_write;
  assign conflict = (state == IDLE) && i_read && d_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // On a conflict the requester that was not served last wins.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (i_read && d_req) begin
          grant_i = last_d;
          grant_d = !last_d;
        end else begin
          grant_i = i_read;
          grant_d = d_req;
        end
        if (grant_i) begin
          state_next = SERVE_I;
        end else if (grant_d) begin
          state_next = SERVE_D;
        end
      end
      SERVE_I: if (l2_resp) state_next = RESP_I;
      SERVE_D: if (l2_resp) state_next = RESP_D;
      RESP_I:  state_next = IDLE;
      RESP_D:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign l2_read  = (state == SERVE_I) || ((state == SERVE_D) && !op_write);
  assign l2_write = (state == SERVE_D) && op_write;
  assign i_resp   = (state == RESP_I);
  assign d_resp   = (state == RESP_D);

  // A D request with both read and write high is carried out as a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d     <= 1'b1;
      op_write   <= 1'b0;
      l2_address <= '0;
      l2_wdata   <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      if (grant_i) begin
        l2_address <= i_address;
        op_write   <= 1'b0;
      end else if (grant_d) begin
        l2_address <= d_address;
        l2_wdata   <= d_wdata;
        op_write   <= d_write;
      end
      if ((state == SERVE_I) && l2_resp) i_rdata <= l2_rdata;
      if ((state == SERVE_D) && l2_resp) d_rdata <= l2_rdata;
      if (state == RESP_I) last_d <= 1'b0;
      if (state == RESP_D) last_d <= 1'b1;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (en && (v != {CNT_W{1'b1}})) ? v + one : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_stall_count  <= '0;
      d_stall_count  <= '0;
      conflict_count <= '0;
    end else if (cnt_clr) begin
      i_stall_count  <= '0;
      d_stall_count  <= '0;
      conflict_count <= '0;
    end else begin
      i_stall_count  <= sat_inc(i_stall_count, i_read && !i_resp);
      d_stall_count  <= sat_inc(d_stall_count, d_req && !d_resp);
      conflict_count <= sat_inc(conflict_count, conflict);
    end
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// tb/tb_l2_arbiter.sv - directed bench for l2_arbiter with a response scoreboard
// Stimulus pushes expected completions; a forked monitor pops and compares on each resp pulse.
module tb_l2_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int CW = 4;

  localparam logic [LW-1:0] LA = {32{8'hA1}};
  localparam logic [LW-1:0] LB = {32{8'hB2}};
  localparam logic [LW-1:0] LC = {32{8'hC3}};
  localparam logic [LW-1:0] LD = {32{8'hD4}};
  localparam logic [LW-1:0] LE = {32{8'hE5}};
  localparam logic [LW-1:0] AA = {32{8'hAA}};
  localparam logic [LW-1:0] W55 = {32{8'h55}};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          l2_read;
  logic          l2_write;
  logic [AW-1:0] l2_address;
  logic [LW-1:0] l2_wdata;
  logic [LW-1:0] l2_rdata;
  logic          l2_resp;
  logic          cnt_clr;
  logic [CW-1:0] i_stall_count;
  logic [CW-1:0] d_stall_count;
  logic [CW-1:0] conflict_count;

  typedef struct {
    bit            is_d;
    logic [LW-1:0] data;
  } resp_t;

  resp_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  l2_arbiter #(.ADDR_W(AW), .LINE_W(LW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .cnt_clr(cnt_clr),
    .i_stall_count(i_stall_count), .d_stall_count(d_stall_count), .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    resp_t e;
    forever begin
      @(negedge clk);
      if (i_resp || d_resp) begin
        check("resp_expected", LW'(exp_q.size() != 0), LW'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("resp_d", LW'(d_resp), LW'(e.is_d));
          check("resp_i", LW'(i_resp), LW'(!e.is_d));
          check("resp_rdata", e.is_d ? d_rdata : i_rdata, e.data);
        end
      end
    end
  endtask

  // Plays the L2 side: waits for a strobe, checks the held request, answers after lat cycles.
  task automatic serve_l2(input bit wr, input logic [AW-1:0] addr, input logic [LW-1:0] wdata,
                          input int lat, input logic [LW-1:0] rdata, output int n);
    n = 0;
    while (!(l2_read || l2_write) && n < 50) begin
      tick();
      n++;
    end
    check("l2_strobe_seen", LW'(l2_read | l2_write), LW'(1));
    for (int k = 0; k <= lat; k++) begin
      check("l2_read", LW'(l2_read), LW'(!wr));
      check("l2_write", LW'(l2_write), LW'(wr));
      check("l2_address", LW'(l2_address), LW'(addr));
      if (wr) check("l2_wdata", l2_wdata, wdata);
      if (k < lat) tick();
    end
    l2_resp  = 1'b1;
    l2_rdata = rdata;
    tick();
    l2_resp  = 1'b0;
    l2_rdata = ~rdata;
    check("l2_strobe_drop", LW'(l2_read | l2_write), LW'(0));
    tick();
  endtask

  initial begin
    int n;
    rst_n = 1'b1; i_read = 1'b0; i_address = '0; d_read = 1'b0; d_write = 1'b0;
    d_address = '0; d_wdata = '0; l2_rdata = '0; l2_resp = 1'b0; cnt_clr = 1'b0;
    fork
      monitor();
    join_none
    #1 rst_n = 1'b0;
    #1;
    check("rst_l2_read", LW'(l2_read), LW'(0));
    check("rst_l2_write", LW'(l2_write), LW'(0));
    check("rst_i_resp", LW'(i_resp), LW'(0));
    check("rst_d_resp", LW'(d_resp), LW'(0));
    check("rst_i_rdata", i_rdata, LW'(0));
    check("rst_d_rdata", d_rdata, LW'(0));
    check("rst_l2_address", LW'(l2_address), LW'(0));
    check("rst_l2_wdata", l2_wdata, LW'(0));
    check("rst_i_stall", LW'(i_stall_count), LW'(0));
    check("rst_d_stall", LW'(d_stall_count), LW'(0));
    check("rst_conflict", LW'(conflict_count), LW'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // First conflict after reset: I wins, then D
    i_read = 1'b1; i_address = 32'h140; d_read = 1'b1; d_address = 32'h2C0;
    exp_q.push_back('{1'b0, LA});
    exp_q.push_back('{1'b1, LB});
    serve_l2(1'b0, 32'h140, '0, 1, LA, n);
    i_read = 1'b0;
    serve_l2(1'b0, 32'h2C0, '0, 0, LB, n);
    d_read = 1'b0;
    check("conflict_first", LW'(conflict_count), LW'(1));
    check("i_stall_conflict", LW'(i_stall_count), LW'(3));
    check("d_stall_conflict", LW'(d_stall_count), LW'(6));

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_i_stall", LW'(i_stall_count), LW'(0));
    check("clr_d_stall", LW'(d_stall_count), LW'(0));
    check("clr_conflict", LW'(conflict_count), LW'(0));

    // I fill of 0x100, L2 answers 3 cycles after l2_read rises
    i_read = 1'b1; i_address = 32'h100;
    exp_q.push_back('{1'b0, AA});
    serve_l2(1'b0, 32'h100, '0, 3, AA, n);
    i_read = 1'b0;
    check("grant_latency", LW'(n), LW'(1));
    check("i_stall_fill", LW'(i_stall_count), LW'(5));

    // Second conflict, I served last so D wins; D read+write acts as write; D inputs move mid-serve
    i_read = 1'b1; i_address = 32'h180;
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h200; d_wdata = W55;
    exp_q.push_back('{1'b1, LC});
    exp_q.push_back('{1'b0, LD});
    tick();
    d_address = 32'h3C0; d_wdata = {32{8'h33}}; d_read = 1'b0;
    serve_l2(1'b1, 32'h200, W55, 2, LC, n);
    d_write = 1'b0;
    serve_l2(1'b0, 32'h180, '0, 1, LD, n);
    i_read = 1'b0;
    check("conflict_second", LW'(conflict_count), LW'(1));
    check("i_rdata_hold", i_rdata, LD);
    check("d_rdata_hold", d_rdata, LC);

    // Reset during SERVE_I, then a stray l2_resp in IDLE
    i_read = 1'b1; i_address = 32'h400;
    tick();
    check("serve_i_active", LW'(l2_read), LW'(1));
    rst_n = 1'b0;
    #1;
    check("abort_l2_read", LW'(l2_read), LW'(0));
    check("abort_i_stall", LW'(i_stall_count), LW'(0));
    check("abort_conflict", LW'(conflict_count), LW'(0));
    check("abort_i_rdata", i_rdata, LW'(0));
    i_read = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    l2_resp = 1'b1; l2_rdata = {32{8'hEE}};
    tick();
    l2_resp = 1'b0;
    check("stray_l2_read", LW'(l2_read | l2_write), LW'(0));
    check("stray_i_rdata", i_rdata, LW'(0));
    check("stray_d_rdata", d_rdata, LW'(0));
    tick();
    check("stray_no_resp", LW'(i_resp | d_resp), LW'(0));

    // Stall counter saturation and clear-overrides-increment
    i_read = 1'b1; i_address = 32'h500;
    repeat (20) tick();
    check("sat_reached", LW'(i_stall_count), LW'(15));
    tick();
    check("sat_held", LW'(i_stall_count), LW'(15));
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("sat_cleared", LW'(i_stall_count), LW'(0));
    tick();
    check("sat_resume", LW'(i_stall_count), LW'(1));
    exp_q.push_back('{1'b0, LE});
    serve_l2(1'b0, 32'h500, '0, 0, LE, n);
    i_read = 1'b0;

    repeat (3) tick();
    check("scoreboard_drained", LW'(exp_q.size()), LW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
